// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED display scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int LED_W     = 4;
    localparam int MIN_PULSE = 2;
    localparam int MIN_HOLD  = 2;

endpackage

// File: rtl/led_rr_arb.sv
// Combinational round-robin winner search: scans upward from ptr+1 with wrap.
module led_rr_arb #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    win_id,
    output logic               win_vld
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx   = (int'(ptr) + off) % NUM_REQ;
            idx_w = idx[ID_W-1:0];
            if (!win_vld && req[idx_w]) begin
                win_vld = 1'b1;
                win_id  = idx_w;
            end
        end
    end

endmodule

// File: rtl/led_sched.sv
// Round-robin scheduler for the shared 4-bit LED display with a minimum display time.
// Optional requester-0 priority/preemption is enabled by defining LED_SCHED_PREEMPT_EN.
module led_sched
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 25000000,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [LED_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     led_en,
    output logic [LED_W-1:0]         led_data,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);

    localparam int MAX_CYC = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic             grant;
    logic [ID_W-1:0]  grant_sel;
    logic             ptr_upd;

    led_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_sel = win_id;
        ptr_upd   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    grant     = 1'b1;
                    state_nxt = ST_PULSE;
                end
`ifdef LED_SCHED_PREEMPT_EN
                // Requester 0 wins outright and leaves the pointer alone so the others stay fair.
                if (req[0]) begin
                    grant     = 1'b1;
                    grant_sel = '0;
                    ptr_upd   = 1'b0;
                    state_nxt = ST_PULSE;
                end
`endif
            end
            ST_PULSE: begin
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_nxt = ST_IDLE;
                end
`ifdef LED_SCHED_PREEMPT_EN
                else if (req[0] && (cnt >= CNT_W'(MIN_HOLD))) begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ptr      <= ID_W'(NUM_REQ - 1);
            ack      <= '0;
            led_en   <= 1'b0;
            led_data <= '0;
            grant_id <= '0;
        end else begin
            state  <= state_nxt;
            // led_en trails the state by one cycle so it rises after the ack cycle.
            led_en <= (state == ST_PULSE);
            ack    <= '0;
            if ((state_nxt != state) || (state == ST_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (grant) begin
                ack      <= NUM_REQ'(1) << grant_sel;
                led_data <= req_data[grant_sel*LED_W +: LED_W];
                grant_id <= grant_sel;
                if (ptr_upd) ptr <= grant_sel;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_led_sched.sv
// Self-checking bench for led_sched: timeline model plus directed literal checks.
module tb_led_sched;

    localparam int N   = 3;
    localparam int P   = 4;
    localparam int H   = 10;
    localparam int IDW = 2;

    logic           sys_clk   = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic [N-1:0]   req       = '0;
    logic [4*N-1:0] req_data  = '0;
    logic [N-1:0]   ack;
    logic           led_en;
    logic [3:0]     led_data;
    logic           busy;
    logic [IDW-1:0] grant_id;

    int tests = 0;
    int fails = 0;

    led_sched #(
        .NUM_REQ      (N),
        .PULSE_CYCLES (P),
        .HOLD_CYCLES  (H)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .led_en    (led_en),
        .led_data  (led_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: g = edge of the last grant, m_end = edge at which the scheduler is idle again.
    int           n      = 0;
    int           g      = -1000;
    int           m_end  = -1;
    int           m_ptr  = N - 1;
    int           m_id   = 0;
    int           w      = -1;
    logic [3:0]   m_data = '0;
    logic [N-1:0] m_ack  = '0;
    bit           chk_en = 1'b0;
    int           en_cnt = 0;
    int           log_edge[$];
    int           log_id[$];
    int           log_dat[$];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            n = 0; g = -1000; m_end = -1; m_ptr = N - 1; m_id = 0; m_data = '0; m_ack = '0;
        end else begin
            n++;
            m_ack = '0;
            if (n > m_end) begin
                w = -1;
`ifdef LED_SCHED_PREEMPT_EN
                if (req[0]) w = 0;
`endif
                for (int k = 1; k <= N; k++)
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                if (w >= 0) begin
                    g        = n;
                    m_end    = n + P + H;
                    m_ack[w] = 1'b1;
                    m_id     = w;
                    m_data   = req_data[4*w +: 4];
`ifdef LED_SCHED_PREEMPT_EN
                    if (w != 0) m_ptr = w;
`else
                    m_ptr = w;
`endif
                end
            end
`ifdef LED_SCHED_PREEMPT_EN
            else if (req[0] && (n - 1 - g - P) >= 2 && (n - 1 - g - P) <= H - 1) begin
                m_end = n;
            end
`endif
            #1;
            if (chk_en && sys_rst_n) begin
                check("ack", 32'(ack), 32'(m_ack));
                check("led_en", 32'(led_en), 32'(n >= g + 1 && n <= g + P));
                check("busy", 32'(busy), 32'(n >= g && n < m_end));
                check("led_data", 32'(led_data), 32'(m_data));
                check("grant_id", 32'(grant_id), 32'(m_id));
                if (ack != '0) begin
                    log_edge.push_back(n);
                    log_id.push_back(int'(grant_id));
                    log_dat.push_back(int'(led_data));
                end
                if (led_en) en_cnt++;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    task automatic wait_ack(input int idx, input int maxc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge sys_clk);
            if (ack[idx]) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: ack[%0d] not seen within %0d cycles", name, idx, maxc);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        req       = '0;
        tick(2);
        sys_rst_n = 1'b1;
        log_edge.delete(); log_id.delete(); log_dat.delete();
    endtask

    initial begin
        // Reset values and an idle stretch with no requests.
        tick(2);
        check("rst_led_en", 32'(led_en), 32'd0);
        check("rst_led_data", 32'(led_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        sys_rst_n = 1'b1;
        chk_en    = 1'b1;
        tick(100);

        // Single request from requester 1.
        en_cnt   = 0;
        req_data = 12'h0A0;
        req      = 3'b010;
        wait_ack(1, 5, "single_ack");
        req = '0;
        tick(25);
        check("single_nacks", 32'(log_id.size()), 32'd1);
        if (log_id.size() >= 1) begin
            check("single_id", 32'(log_id[0]), 32'd1);
            check("single_data", 32'(log_dat[0]), 32'hA);
        end
        check("single_en_cycles", 32'(en_cnt), 32'd4);

        // All three requesting continuously from a fresh pointer.
        do_reset();
        req_data = 12'h321;
        req      = 3'b111;
        tick(4 * 15 + 2);
        req = '0;
        tick(20);
        check("rr_nacks", 32'(log_id.size()), 32'd5);
        if (log_id.size() >= 4) begin
            check("rr_id0", 32'(log_id[0]), 32'd0);
            check("rr_id1", 32'(log_id[1]), 32'd1);
            check("rr_id2", 32'(log_id[2]), 32'd2);
            check("rr_id3", 32'(log_id[3]), 32'd0);
            check("rr_dat0", 32'(log_dat[0]), 32'd1);
            check("rr_dat1", 32'(log_dat[1]), 32'd2);
            check("rr_dat2", 32'(log_dat[2]), 32'd3);
            check("rr_dat3", 32'(log_dat[3]), 32'd1);
            check("rr_gap1", 32'(log_edge[1] - log_edge[0]), 32'd15);
            check("rr_gap3", 32'(log_edge[3] - log_edge[2]), 32'd15);
        end

        // Requester 2 withdraws while requester 0 is being served.
        do_reset();
        req_data = 12'h5C7;
        req      = 3'b101;
        wait_ack(0, 5, "withdraw_ack0");
        req = '0;
        tick(5);
        req = 3'b011;
        wait_ack(1, 20, "withdraw_ack1");
        req = '0;
        tick(20);
        check("withdraw_nacks", 32'(log_id.size()), 32'd2);
        if (log_id.size() >= 2) begin
            check("withdraw_id0", 32'(log_id[0]), 32'd0);
            check("withdraw_id1", 32'(log_id[1]), 32'd1);
            check("withdraw_dat1", 32'(log_dat[1]), 32'hC);
        end

        // Reset in the middle of the pulse.
        req_data = 12'h9E6;
        req      = 3'b001;
        wait_ack(0, 25, "midrst_ack");
        req = '0;
        tick(2);
        check("midrst_en_before", 32'(led_en), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_en", 32'(led_en), 32'd0);
        check("midrst_data", 32'(led_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick(1);
        sys_rst_n = 1'b1;
        req       = 3'b100;
        @(posedge sys_clk);
        #1;
        check("midrst_next_ack", 32'(ack), 32'b100);
        check("midrst_next_data", 32'(led_data), 32'h9);
        tick(1);
        req = '0;
        tick(20);

`ifdef LED_SCHED_PREEMPT_EN
        // Requester 0 cuts the hold short once the display has been dark for two cycles.
        do_reset();
        req_data = 12'h0B4;
        req      = 3'b010;
        wait_ack(1, 5, "preempt_ack1");
        req = '0;
        tick(P + 2);
        req = 3'b001;
        wait_ack(0, 20, "preempt_ack0");
        req = '0;
        tick(20);
        check("preempt_nacks", 32'(log_id.size()), 32'd2);
        if (log_id.size() >= 2) begin
            check("preempt_id", 32'(log_id[1]), 32'd0);
            check("preempt_gap", 32'(log_edge[1] - log_edge[0]), 32'd8);
            check("preempt_dat", 32'(log_dat[1]), 32'h4);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
